// File: rtl/reg_file_param.sv
// reg_file_param: 2-read/1-write register file for cipher key/state storage.
// Latency: registered reads (1 cycle) with write-first bypass; clear sweep of DEPTH cycles.
// Backpressure: busy high during sweep; writes then (or out of range) are dropped and flagged on wr_err.
// Optional parity: define REGFILE_PARITY_EN for per-entry even parity plus inj_perr/rdN_perr ports.
module reg_file_param #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd0_addr,
  input  logic [AW-1:0]    rd1_addr,
  output logic [WIDTH-1:0] rd0_data,
  output logic [WIDTH-1:0] rd1_data,
  output logic             rd0_valid,
  output logic             rd1_valid,
  output logic             busy,
  output logic             wr_err
`ifdef REGFILE_PARITY_EN
  ,
  input  logic             inj_perr,
  output logic             rd0_perr,
  output logic             rd1_perr
`endif
);

  localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LP_LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] LP_ONE   = AW'(1);

  typedef enum logic {ST_SWEEP, ST_IDLE} state_t;

  state_t           r_state;
  logic [AW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
`ifdef REGFILE_PARITY_EN
  logic [DEPTH-1:0] r_par;
  logic             w_rd0_perr;
  logic             w_rd1_perr;
`endif

  logic             w_busy;
  logic             w_wr_acc;
  logic [WIDTH-1:0] w_rd0_dat;
  logic [WIDTH-1:0] w_rd1_dat;
  logic             w_rd0_vld;
  logic             w_rd1_vld;

  assign w_busy   = (r_state == ST_SWEEP);
  assign busy     = w_busy;
  assign w_wr_acc = wr_en && !w_busy && ({1'b0, wr_addr} < LP_DEPTH);

  // Sweep FSM: rst/clr (re)start at entry 0, leave after the last entry is cleared
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_state <= ST_SWEEP;
      r_cnt   <= '0;
    end else if (r_state == ST_SWEEP) begin
      if (r_cnt == LP_LAST) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + LP_ONE;
      end
    end
  end

  // Storage update: sweep clears one entry per cycle, otherwise accept writes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else if (w_busy) begin
      if (!clr) begin
        r_mem[r_cnt] <= '0;
        r_vld[r_cnt] <= 1'b0;
`ifdef REGFILE_PARITY_EN
        r_par[r_cnt] <= 1'b0;
`endif
      end
    end else if (w_wr_acc) begin
      r_mem[wr_addr] <= wr_data;
      r_vld[wr_addr] <= 1'b1;
`ifdef REGFILE_PARITY_EN
      r_par[wr_addr] <= (^wr_data) ^ inj_perr;
`endif
    end
  end

  // Read selection: write-first bypass, else stored entry if valid and not sweeping
  always_comb begin
    w_rd0_dat = '0;
    w_rd0_vld = 1'b0;
    w_rd1_dat = '0;
    w_rd1_vld = 1'b0;
`ifdef REGFILE_PARITY_EN
    w_rd0_perr = 1'b0;
    w_rd1_perr = 1'b0;
`endif
    if (w_wr_acc && (wr_addr == rd0_addr)) begin
      w_rd0_dat = wr_data;
      w_rd0_vld = 1'b1;
    end else if (!w_busy && ({1'b0, rd0_addr} < LP_DEPTH) && r_vld[rd0_addr]) begin
      w_rd0_dat = r_mem[rd0_addr];
      w_rd0_vld = 1'b1;
`ifdef REGFILE_PARITY_EN
      w_rd0_perr = r_par[rd0_addr] ^ (^r_mem[rd0_addr]);
`endif
    end
    if (w_wr_acc && (wr_addr == rd1_addr)) begin
      w_rd1_dat = wr_data;
      w_rd1_vld = 1'b1;
    end else if (!w_busy && ({1'b0, rd1_addr} < LP_DEPTH) && r_vld[rd1_addr]) begin
      w_rd1_dat = r_mem[rd1_addr];
      w_rd1_vld = 1'b1;
`ifdef REGFILE_PARITY_EN
      w_rd1_perr = r_par[rd1_addr] ^ (^r_mem[rd1_addr]);
`endif
    end
  end

  // Registered read outputs and one-cycle write-reject pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      rd0_data  <= '0;
      rd1_data  <= '0;
      rd0_valid <= 1'b0;
      rd1_valid <= 1'b0;
      wr_err    <= 1'b0;
`ifdef REGFILE_PARITY_EN
      rd0_perr  <= 1'b0;
      rd1_perr  <= 1'b0;
`endif
    end else begin
      rd0_data  <= w_rd0_dat;
      rd1_data  <= w_rd1_dat;
      rd0_valid <= w_rd0_vld;
      rd1_valid <= w_rd1_vld;
      wr_err    <= wr_en && !w_wr_acc;
`ifdef REGFILE_PARITY_EN
      rd0_perr  <= w_rd0_perr;
      rd1_perr  <= w_rd1_perr;
`endif
    end
  end

endmodule
